// File: rtl/pass_counter_checker.sv
// pass_counter_checker
//   Receive-side checker for an incrementing (wrapping) counter stream coming
//   back from the fabric. It locks onto the sequence after LOCK_COUNT
//   consecutive in-sequence samples, then flags every break in it and keeps
//   saturating error statistics for readback.
//
// State table
//   state       | meaning
//   ST_UNLOCKED | no history; the next valid sample seeds the prediction
//   ST_ACQUIRE  | counting consecutive in-sequence samples toward lock
//   ST_LOCKED   | sequence tracked; any mismatch is reported as an error
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   sample_valid in   sample is consumed only when high
//   sample       in   received stream value (WIDTH bits)
//   clear        in   clears error_count and fail_sticky
//   locked       out  high while in ST_LOCKED (registered)
//   error_pulse  out  one-cycle pulse per in-lock mismatch
//   error_count  out  saturating count of in-lock mismatches
//   fail_sticky  out  set by any in-lock mismatch, held until clear/reset
//   expected     out  next predicted sample value
module pass_counter_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     sample,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 fail_sticky,
  output logic [WIDTH-1:0]     expected
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]           HIT_ONE = 4'd1;
  localparam logic [WIDTH-1:0]     EXP_ONE = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [3:0]           hits_q, hits_d;
  logic [ERR_CNT_W-1:0] error_count_q;
  logic                 error_pulse_q;
  logic                 fail_sticky_q;
  logic                 locked_q;
  logic                 lock_miss;
  logic                 sample_match;

  assign sample_match = (sample == expected_q);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    hits_d     = hits_q;
    lock_miss  = 1'b0;
    if (sample_valid) begin
      case (state_q)
        ST_UNLOCKED: begin
          expected_d = sample + EXP_ONE;
          hits_d     = HIT_ONE;
          state_d    = (LOCK_N == HIT_ONE) ? ST_LOCKED : ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (sample_match) begin
            hits_d     = hits_q + HIT_ONE;
            expected_d = expected_q + EXP_ONE;
            if ((hits_q + HIT_ONE) == LOCK_N) begin
              state_d = ST_LOCKED;
            end
          end else begin
            // Restart acquisition from this sample; never an error here.
            expected_d = sample + EXP_ONE;
            hits_d     = HIT_ONE;
          end
        end
        ST_LOCKED: begin
          if (sample_match) begin
            expected_d = expected_q + EXP_ONE;
          end else begin
            lock_miss  = 1'b1;
            expected_d = sample + EXP_ONE;
            hits_d     = HIT_ONE;
            // With LOCK_COUNT of 1 the failing sample alone re-locks.
            state_d    = (LOCK_N > HIT_ONE) ? ST_ACQUIRE : ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_UNLOCKED;
      expected_q    <= '0;
      hits_q        <= '0;
      error_count_q <= '0;
      error_pulse_q <= 1'b0;
      fail_sticky_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      hits_q        <= hits_d;
      error_pulse_q <= lock_miss;
      // Decode from next state so locked lines up with the other outputs.
      locked_q      <= (state_d == ST_LOCKED);
      if (lock_miss) begin
        // A coincident clear still leaves this error recorded.
        fail_sticky_q <= 1'b1;
        if (clear) begin
          error_count_q <= CNT_ONE;
        end else if (error_count_q != CNT_MAX) begin
          error_count_q <= error_count_q + CNT_ONE;
        end
      end else if (clear) begin
        error_count_q <= '0;
        fail_sticky_q <= 1'b0;
      end
    end
  end

  assign locked      = locked_q;
  assign error_pulse = error_pulse_q;
  assign error_count = error_count_q;
  assign fail_sticky = fail_sticky_q;
  assign expected    = expected_q;

endmodule

// File: tb/tb_pass_counter_checker.sv
module tb_pass_counter_checker;

  logic       clk;
  logic       reset;
  logic       sample_valid;
  logic [3:0] sample;
  logic       clear;

  logic       m_locked, m_pulse, m_fail;
  logic [7:0] m_cnt;
  logic [3:0] m_exp;

  logic       s_locked, s_pulse, s_fail;
  logic [1:0] s_cnt;
  logic [3:0] s_exp;

  int total = 0;
  int bad   = 0;

  pass_counter_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) u_main (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .clear       (clear),
    .locked      (m_locked),
    .error_pulse (m_pulse),
    .error_count (m_cnt),
    .fail_sticky (m_fail),
    .expected    (m_exp)
  );

  pass_counter_checker #(.WIDTH(4), .LOCK_COUNT(1), .ERR_CNT_W(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .clear       (clear),
    .locked      (s_locked),
    .error_pulse (s_pulse),
    .error_count (s_cnt),
    .fail_sticky (s_fail),
    .expected    (s_exp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [3:0] smp;
    logic       clr;
    logic       e_locked;
    logic       e_pulse;
    logic [7:0] e_cnt;
    logic       e_fail;
    logic [3:0] e_exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic valid, input logic [3:0] smp,
                     input logic clr, input logic e_locked, input logic e_pulse,
                     input logic [7:0] e_cnt, input logic e_fail, input logic [3:0] e_exp);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.smp = smp; v.clr = clr;
    v.e_locked = e_locked; v.e_pulse = e_pulse; v.e_cnt = e_cnt;
    v.e_fail = e_fail; v.e_exp = e_exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input logic rst_n, input logic valid, input logic [3:0] smp,
                       input logic clr);
    @(negedge clk);
    reset        = rst_n;
    sample_valid = valid;
    sample       = smp;
    clear        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sat(input string tag, input logic e_locked, input logic e_pulse,
                         input logic [7:0] e_cnt, input logic e_fail, input logic [3:0] e_exp);
    chk({tag, " locked"}, {7'd0, s_locked}, {7'd0, e_locked});
    chk({tag, " pulse"},  {7'd0, s_pulse},  {7'd0, e_pulse});
    chk({tag, " count"},  {6'd0, s_cnt},    e_cnt);
    chk({tag, " fail"},   {7'd0, s_fail},   {7'd0, e_fail});
    chk({tag, " expected"}, {4'd0, s_exp},  {4'd0, e_exp});
  endtask

  initial begin
    reset = 1'b0; sample_valid = 1'b0; sample = '0; clear = 1'b0;

    //  rst val smp clr | lck pls cnt fail exp
    // reset with valid traffic
    add(0, 1,  7, 0,   0, 0, 0, 0,  0);
    add(0, 1, 11, 0,   0, 0, 0, 0,  0);
    // lock and wrap
    add(1, 1, 13, 0,   0, 0, 0, 0, 14);
    add(1, 1, 14, 0,   0, 0, 0, 0, 15);
    add(1, 1, 15, 0,   1, 0, 0, 0,  0);
    add(1, 1,  0, 0,   1, 0, 0, 0,  1);
    add(1, 1,  1, 0,   1, 0, 0, 0,  2);
    // skip while locked
    add(1, 1,  2, 0,   1, 0, 0, 0,  3);
    add(1, 1,  3, 0,   1, 0, 0, 0,  4);
    add(1, 1,  4, 0,   1, 0, 0, 0,  5);
    add(1, 1,  5, 0,   1, 0, 0, 0,  6);
    add(1, 1,  6, 0,   1, 0, 0, 0,  7);
    add(1, 1,  8, 0,   0, 1, 1, 1,  9);
    add(1, 1,  9, 0,   0, 0, 1, 1, 10);
    add(1, 1, 10, 0,   1, 0, 1, 1, 11);
    // clear alone leaves lock/expected; invalid sample is ignored
    add(1, 0,  0, 1,   1, 0, 0, 0, 11);
    add(1, 0,  3, 0,   1, 0, 0, 0, 11);
    // valid gaps and acquire noise
    add(0, 0,  0, 0,   0, 0, 0, 0,  0);
    add(1, 1,  2, 0,   0, 0, 0, 0,  3);
    add(1, 0,  9, 0,   0, 0, 0, 0,  3);
    add(1, 0,  9, 0,   0, 0, 0, 0,  3);
    add(1, 0,  9, 0,   0, 0, 0, 0,  3);
    add(1, 1,  3, 0,   0, 0, 0, 0,  4);
    add(1, 1,  7, 0,   0, 0, 0, 0,  8);
    add(1, 1,  8, 0,   0, 0, 0, 0,  9);
    add(1, 1,  9, 0,   1, 0, 0, 0, 10);
    // reset mid-lock, then re-acquire from the first post-reset sample
    add(1, 1, 10, 0,   1, 0, 0, 0, 11);
    add(1, 1,  3, 0,   0, 1, 1, 1,  4);
    add(1, 1,  4, 0,   0, 0, 1, 1,  5);
    add(1, 1,  5, 0,   1, 0, 1, 1,  6);
    add(0, 1,  6, 0,   0, 0, 0, 0,  0);
    add(1, 1, 12, 0,   0, 0, 0, 0, 13);
    add(1, 1, 13, 0,   0, 0, 0, 0, 14);
    add(1, 1, 14, 0,   1, 0, 0, 0, 15);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].valid, vecs[i].smp, vecs[i].clr);
      chk($sformatf("row%0d locked", i),   {7'd0, m_locked}, {7'd0, vecs[i].e_locked});
      chk($sformatf("row%0d pulse", i),    {7'd0, m_pulse},  {7'd0, vecs[i].e_pulse});
      chk($sformatf("row%0d count", i),    m_cnt,            vecs[i].e_cnt);
      chk($sformatf("row%0d fail", i),     {7'd0, m_fail},   {7'd0, vecs[i].e_fail});
      chk($sformatf("row%0d expected", i), {4'd0, m_exp},    {4'd0, vecs[i].e_exp});
    end

    // Saturation and clear on the LOCK_COUNT=1, 2-bit counter instance.
    apply(0, 0, 0, 0);
    chk_sat("sat reset", 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0);
    chk_sat("sat lock1", 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] s;
      logic [7:0] c;
      s = (i % 2 == 0) ? 4'd5 : 4'd0;
      c = (i + 1 > 3) ? 8'd3 : 8'(i + 1);
      apply(1, 1, s, 0);
      chk_sat($sformatf("sat miss%0d", i), 1, 1, c, 1, s + 4'd1);
    end
    apply(1, 1, 0, 1);
    chk_sat("sat clear+miss", 1, 1, 1, 1, 1);
    apply(1, 1, 1, 1);
    chk_sat("sat clear", 1, 0, 0, 0, 2);
    apply(1, 0, 7, 0);
    chk_sat("sat idle", 1, 0, 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pass_counter_checker.md
Name: pass_counter_checker

Overview:
- Receive-side counterpart to the fabric counter generator test design.
- Samples a WIDTH-bit stream arriving from the fabric output-pass pins, e.g. a wrapping binary counter.
- Locks onto the incrementing sequence, flags every break in it and keeps saturating error statistics.
- Sits in the bring-up and test harness; its results are exported through input-pass pins for readback.

Parameters:
- WIDTH, 4, width of the received sample (matches the 4-bit pass primitives).
- LOCK_COUNT, 3, consecutive in-sequence samples needed to declare lock; legal range 1..15.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- sample_valid  input  1  sample is consumed only in cycles where this is high.
- sample  input  WIDTH  received stream value.
- clear  input  1  synchronous clear of error_count and fail_sticky only.
- locked  output  1  high while in state LOCKED.
- error_pulse  output  1  one-cycle pulse, registered, on each in-lock mismatch.
- error_count  output  ERR_CNT_W  number of in-lock mismatches, saturating.
- fail_sticky  output  1  set by any in-lock mismatch; held until clear or reset.
- expected  output  WIDTH  next value the checker predicts.

Behaviour:

Reset (reset == 0 at a clock edge):
- State goes to UNLOCKED.
- hits, expected, error_count and error_pulse go to 0; locked and fail_sticky go to 0.
- Reset overrides every other input, including mid-acquire or mid-lock.

Arithmetic:
- expected is always (last accepted sample + 1) mod 2^WIDTH; wrap from all-ones to 0 is legal and counts as in sequence.
- hits is a 4-bit internal counter and never exceeds LOCK_COUNT.

Cycles with sample_valid == 0:
- State, expected and hits hold; error_pulse is 0.

UNLOCKED:
- On a valid sample: expected <= sample+1 and hits <= 1.
- Goes to LOCKED if LOCK_COUNT == 1, otherwise to ACQUIRE.

ACQUIRE:
- On a valid sample equal to expected: hits <= hits+1 and expected <= expected+1. When hits+1 == LOCK_COUNT, go to LOCKED.
- On a valid sample not equal to expected: expected <= sample+1, hits <= 1, stay in ACQUIRE.
- Mismatches in ACQUIRE never raise errors.

LOCKED:
- On a valid sample equal to expected: expected <= expected+1.
- On a valid sample not equal to expected:
  - error_pulse <= 1 for exactly the next cycle;
  - error_count increments, saturating at 2^ERR_CNT_W-1;
  - fail_sticky <= 1;
  - expected <= sample+1 and hits <= 1;
  - next state is ACQUIRE if LOCK_COUNT > 1, otherwise stay in LOCKED.

Output timing:
- locked is a registered decode of the state: it rises in the cycle after the locking sample and falls in the cycle after the failing sample.

clear:
- Clears error_count and fail_sticky; does not affect state, expected or hits.
- If clear and an in-lock mismatch occur in the same cycle, the result is error_count = 1, fail_sticky = 1, error_pulse = 1 (the error wins).

Latency:
- Every output is registered, so there is one cycle from a sample edge to the visible response.
- No combinational path from any input to any output.

Test Plan:
1. Reset: hold reset=0 for 2 cycles while driving random samples with valid=1 -> locked=0, error_count=0, fail_sticky=0, expected=0, error_pulse=0.
2. Lock and wrap: WIDTH=4, LOCK_COUNT=3, stream 13,14,15,0,1 with valid=1 -> locked rises the cycle after sample 15; values 0 and 1 produce no error; expected=2 at the end.
3. Skip while locked: after locking, stream 5,6,8,9,10 -> single error_pulse after 8, error_count=1, fail_sticky=1; locked drops; re-lock after 10 (8,9,10 form 3 hits); expected=11.
4. Valid gaps and acquire noise: samples 2,(valid=0 for 3 cycles),3,7,8,9 -> no error_pulse at any point; locked rises after 9; expected=10.
5. Saturation and clear: ERR_CNT_W=2, force 5 in-lock mismatches (LOCK_COUNT=1) -> error_count stays 3; clear coincident with a 6th mismatch -> error_count=1, fail_sticky=1.
6. Reset mid-lock: locked=1, assert reset=0 for one cycle during a valid stream -> next cycle locked=0, error_count=0; re-acquisition begins from the first post-reset sample.
